reorder_buffer: RTL and testbench

- In-order retirement end of the register-renaming pipeline.
- Decode dispatches each instruction after rename and receives an active-list tag. Execute reports results out of order by tag.
- This block retires entries in program order and drives the register file write-back port: wb_write_enable, wb_physical_write_addr, wb_physical_write_data and wb_active_list_index.

---
 rtl/reorder_buffer_pkg.sv | 13 +
 rtl/reorder_buffer.sv | 111 +++++++++++
 tb/tb_reorder_buffer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// Purpose: shared widths for the reorder buffer and its register-file neighbours.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package reorder_buffer_pkg;

    // Result data width, matches the register file data bus.
    localparam int ROB_DATA_WIDTH = 32;
    // Physical register index width, matches the register file physical bus.
    localparam int ROB_PREG_WIDTH = 6;
    // Active-list index width; depth is 1 << ROB_TAG_WIDTH.
    localparam int ROB_TAG_WIDTH  = 5;

endpackage

// File: rtl/reorder_buffer.sv
// Purpose: in-order retirement of renamed instructions; drives the regfile write-back port.
// Latency: completion of the head entry at edge E retires at E+1, wb_* visible the cycle after.
// Backpressure: disp_ready = !full from pre-edge pointers; completions and retires never stall.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = ROB_DATA_WIDTH,
    parameter int PREG_WIDTH = ROB_PREG_WIDTH,
    parameter int TAG_WIDTH  = ROB_TAG_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_in,
    input  logic                  disp_valid,
    output logic                  disp_ready,
    input  logic                  disp_has_dest,
    input  logic [PREG_WIDTH-1:0] disp_preg_addr,
    output logic [TAG_WIDTH-1:0]  disp_tag,
    input  logic                  cmp_valid,
    input  logic [TAG_WIDTH-1:0]  cmp_tag,
    input  logic [DATA_WIDTH-1:0] cmp_data,
    output logic                  wb_retire_valid,
    output logic                  wb_write_enable,
    output logic [PREG_WIDTH-1:0] wb_physical_write_addr,
    output logic [DATA_WIDTH-1:0] wb_physical_write_data,
    output logic [TAG_WIDTH-1:0]  wb_active_list_index,
    output logic [TAG_WIDTH:0]    count
);

    localparam int DEPTH = 1 << TAG_WIDTH;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [TAG_WIDTH:0]    head;
    logic [TAG_WIDTH:0]    tail;
    logic [TAG_WIDTH-1:0]  head_idx;
    logic [TAG_WIDTH-1:0]  tail_idx;

    // Entry state is plain registers: completions write at random tags while retire reads head.
    logic [DEPTH-1:0]      ent_vld;
    logic [DEPTH-1:0]      ent_done;
    logic [DEPTH-1:0]      ent_has_dest;
    logic [PREG_WIDTH-1:0] ent_preg [DEPTH];
    logic [DATA_WIDTH-1:0] ent_dat  [DEPTH];

    logic full;
    logic disp_fire;
    logic cmp_fire;
    logic retire;

    assign head_idx   = head[TAG_WIDTH-1:0];
    assign tail_idx   = tail[TAG_WIDTH-1:0];
    assign full       = (head_idx == tail_idx) && (head[TAG_WIDTH] != tail[TAG_WIDTH]);
    assign disp_ready = !full;
    assign disp_tag   = tail_idx;
    assign count      = tail - head;

    assign disp_fire = disp_valid && disp_ready;
    // A completion to the entry being dispatched this cycle sees valid=0 and is dropped.
    assign cmp_fire  = cmp_valid && ent_vld[cmp_tag];
    // Retire needs done already registered, so it can never coincide with the first
    // completion of the same tag.
    assign retire    = ent_vld[head_idx] && ent_done[head_idx];

    // Entry array and pointer update; flush and reset discard everything in flight.
    always_ff @(posedge clk) begin
        if (!rst_n || flush_in) begin
            head     <= '0;
            tail     <= '0;
            ent_vld  <= '0;
            ent_done <= '0;
        end else begin
            if (cmp_fire) begin
                ent_done[cmp_tag] <= 1'b1;
                ent_dat[cmp_tag]  <= cmp_data;
            end
            // Dispatch never targets the head slot while it holds a live entry (that is full).
            if (disp_fire) begin
                ent_vld[tail_idx]      <= 1'b1;
                ent_done[tail_idx]     <= 1'b0;
                ent_has_dest[tail_idx] <= disp_has_dest;
                ent_preg[tail_idx]     <= disp_preg_addr;
                tail                   <= tail + 1'b1;
            end
            // Placed last so a retire clear wins over any late re-completion of the head.
            if (retire) begin
                ent_vld[head_idx]  <= 1'b0;
                ent_done[head_idx] <= 1'b0;
                head               <= head + 1'b1;
            end
        end
    end

    // Registered write-back port: a one-cycle pulse per retire, all zero otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n || flush_in || !retire) begin
            wb_retire_valid        <= 1'b0;
            wb_write_enable        <= 1'b0;
            wb_physical_write_addr <= '0;
            wb_physical_write_data <= '0;
            wb_active_list_index   <= '0;
        end else begin
            wb_retire_valid        <= 1'b1;
            // Physical register 0 is hardwired, so it is never written.
            wb_write_enable        <= ent_has_dest[head_idx] && (ent_preg[head_idx] != '0);
            wb_physical_write_addr <= ent_preg[head_idx];
            wb_physical_write_data <= ent_dat[head_idx];
            wb_active_list_index   <= head_idx;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Purpose: directed stimulus with a retire scoreboard for reorder_buffer.
// Latency: inputs change 1 time unit after posedge; the monitor samples on negedge.
// Backpressure: stimulus checks disp_ready directly; every retire pops one expectation.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_in;
    logic        disp_valid;
    logic        disp_ready;
    logic        disp_has_dest;
    logic [5:0]  disp_preg_addr;
    logic [4:0]  disp_tag;
    logic        cmp_valid;
    logic [4:0]  cmp_tag;
    logic [31:0] cmp_data;
    logic        wb_retire_valid;
    logic        wb_write_enable;
    logic [5:0]  wb_physical_write_addr;
    logic [31:0] wb_physical_write_data;
    logic [4:0]  wb_active_list_index;
    logic [5:0]  count;

    typedef struct {
        logic [4:0]  tag;
        logic        we;
        logic [5:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    logic mon_en   = 1'b0;

    reorder_buffer #(.DATA_WIDTH(32), .PREG_WIDTH(6), .TAG_WIDTH(5)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .flush_in               (flush_in),
        .disp_valid             (disp_valid),
        .disp_ready             (disp_ready),
        .disp_has_dest          (disp_has_dest),
        .disp_preg_addr         (disp_preg_addr),
        .disp_tag               (disp_tag),
        .cmp_valid              (cmp_valid),
        .cmp_tag                (cmp_tag),
        .cmp_data               (cmp_data),
        .wb_retire_valid        (wb_retire_valid),
        .wb_write_enable        (wb_write_enable),
        .wb_physical_write_addr (wb_physical_write_addr),
        .wb_physical_write_data (wb_physical_write_data),
        .wb_active_list_index   (wb_active_list_index),
        .count                  (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input logic [4:0] tag, input logic we, input logic [5:0] addr,
                        input logic [31:0] data);
        exp_t e;
        e.tag = tag; e.we = we; e.addr = addr; e.data = data;
        sb.push_back(e);
    endtask

    task automatic dispatch(input logic hd, input logic [5:0] preg, input logic [4:0] exp_tag);
        disp_valid     = 1'b1;
        disp_has_dest  = hd;
        disp_preg_addr = preg;
        #1;
        chk("disp_tag", 64'(disp_tag), 64'(exp_tag));
        chk("disp_ready", 64'(disp_ready), 64'd1);
        tick();
        disp_valid = 1'b0;
    endtask

    task automatic complete(input logic [4:0] tag, input logic [31:0] data);
        cmp_valid = 1'b1;
        cmp_tag   = tag;
        cmp_data  = data;
        tick();
        cmp_valid = 1'b0;
    endtask

    // Monitor: each retire pulse pops one expectation; idle cycles must show all-zero wb_*.
    always @(negedge clk) begin
        if (mon_en) begin
            if (wb_retire_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_retire: got tag %0d expected no retire",
                             wb_active_list_index);
                end else begin
                    mon_e = sb.pop_front();
                    chk("ret_tag",  64'(wb_active_list_index),   64'(mon_e.tag));
                    chk("ret_we",   64'(wb_write_enable),        64'(mon_e.we));
                    chk("ret_addr", 64'(wb_physical_write_addr), 64'(mon_e.addr));
                    chk("ret_data", 64'(wb_physical_write_data), 64'(mon_e.data));
                end
            end else begin
                chk("wb_idle", 64'({wb_retire_valid, wb_write_enable, wb_physical_write_addr,
                                    wb_physical_write_data, wb_active_list_index}), 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected run to finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; flush_in = 1'b0; disp_valid = 1'b0; disp_has_dest = 1'b0;
        disp_preg_addr = '0; cmp_valid = 1'b0; cmp_tag = '0; cmp_data = '0;
        idle(2);
        rst_n = 1'b1;
        mon_en = 1'b1;
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_ready", 64'(disp_ready), 64'd1);
        chk("reset_wb", 64'(wb_retire_valid), 64'd0);

        // In-order retire of out-of-order completions.
        dispatch(1'b1, 6'd33, 5'd0);
        dispatch(1'b1, 6'd34, 5'd1);
        dispatch(1'b1, 6'd35, 5'd2);
        chk("count3", 64'(count), 64'd3);
        push(5'd0, 1'b1, 6'd33, 32'hA);
        push(5'd1, 1'b1, 6'd34, 32'hB);
        push(5'd2, 1'b1, 6'd35, 32'hC);
        complete(5'd2, 32'hC);
        complete(5'd0, 32'hA);
        chk("lat_not_yet", 64'(wb_retire_valid), 64'd0);
        complete(5'd1, 32'hB);
        chk("lat_two_edges", 64'({wb_retire_valid, wb_active_list_index}), 64'({1'b1, 5'd0}));
        idle(3);
        chk("drain1_count", 64'(count), 64'd0);

        // No destination, and destination preg 0: retire without a register write.
        dispatch(1'b0, 6'd5, 5'd3);
        dispatch(1'b1, 6'd0, 5'd4);
        push(5'd3, 1'b0, 6'd5, 32'h11);
        push(5'd4, 1'b0, 6'd0, 32'h22);
        complete(5'd3, 32'h11);
        complete(5'd4, 32'h22);
        idle(3);
        chk("drain2_count", 64'(count), 64'd0);

        // Mid-run reset, then fill to capacity.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst2_count", 64'(count), 64'd0);
        chk("rst2_tag", 64'(disp_tag), 64'd0);
        for (int i = 0; i < 32; i++) dispatch(1'b1, 6'(i + 1), 5'(i));
        chk("full_ready", 64'(disp_ready), 64'd0);
        chk("full_count", 64'(count), 64'd32);
        // 33rd dispatch held across the retire edge: refused because pre-edge state is full.
        disp_valid = 1'b1; disp_has_dest = 1'b1; disp_preg_addr = 6'd50;
        push(5'd0, 1'b1, 6'd1, 32'h100);
        complete(5'd0, 32'h100);
        chk("full_refuse_count", 64'(count), 64'd32);
        chk("full_refuse_ready", 64'(disp_ready), 64'd0);
        tick();
        disp_valid = 1'b0;
        chk("after_retire_count", 64'(count), 64'd31);
        chk("after_retire_ready", 64'(disp_ready), 64'd1);
        for (int i = 1; i < 32; i++) begin
            push(5'(i), 1'b1, 6'(i + 1), 32'h100 + 32'(i));
            complete(5'(i), 32'h100 + 32'(i));
        end
        idle(4);
        chk("drain3_count", 64'(count), 64'd0);

        // Wrap: index restarts at 0 after 31, and the pointer wrap bit toggles.
        for (int i = 0; i < 40; i++) begin
            push(5'(i % 32), 1'b1, 6'((i % 62) + 1), 32'h200 + 32'(i));
            dispatch(1'b1, 6'((i % 62) + 1), 5'(i % 32));
            complete(5'(i % 32), 32'h200 + 32'(i));
            chk("wrap_count_le32", 64'(count <= 6'd32), 64'd1);
        end
        idle(3);
        chk("drain4_count", 64'(count), 64'd0);

        // Flush with five pending entries (tags 8..12), a completion on the second one,
        // and a dispatch attempt in the same cycle: all discarded.
        for (int i = 0; i < 5; i++) dispatch(1'b1, 6'(10 + i), 5'(8 + i));
        chk("pre_flush_count", 64'(count), 64'd5);
        flush_in = 1'b1; cmp_valid = 1'b1; cmp_tag = 5'd9; cmp_data = 32'hDEAD;
        disp_valid = 1'b1; disp_has_dest = 1'b1; disp_preg_addr = 6'd20;
        tick();
        flush_in = 1'b0; cmp_valid = 1'b0; disp_valid = 1'b0;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_tag", 64'(disp_tag), 64'd0);
        chk("flush_ready", 64'(disp_ready), 64'd1);
        complete(5'd8, 32'hBEEF);
        idle(3);
        chk("post_flush_count", 64'(count), 64'd0);
        push(5'd0, 1'b1, 6'd7, 32'h77);
        dispatch(1'b1, 6'd7, 5'd0);
        chk("post_flush_one", 64'(count), 64'd1);
        complete(5'd0, 32'h77);
        idle(3);
        chk("final_count", 64'(count), 64'd0);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
